// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IF/DM unified-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned AW_DEF       = 32;
    localparam int unsigned DW_DEF       = 32;
    localparam int unsigned MAX_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    // Bits needed to count 0..max_val inclusive, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter, seen from both ends.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);

    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic [DW-1:0]     if_rdata;
    logic              if_ack;

    logic              dm_req;
    logic              dm_we;
    logic [DW/8-1:0]   dm_be;
    logic [AW-1:0]     dm_addr;
    logic [DW-1:0]     dm_wdata;
    logic [DW-1:0]     dm_rdata;
    logic              dm_ack;

    logic              mem_req;
    logic              mem_we;
    logic [DW/8-1:0]   mem_be;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              mem_ready;

    // Arbiter view
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  mem_rdata, mem_ready,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    // Environment view: requesters plus memory model
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output mem_rdata, mem_ready,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data port has priority, fetch is forced after
// MAX_WAIT consecutive data grants while it waits.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned    BW       = DW / 8;
    localparam int unsigned    WCW      = cnt_width(MAX_WAIT);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    state_e          state_q,     state_d;
    owner_e          owner_q,     owner_d;
    logic [WCW-1:0]  wait_q,      wait_d;

    logic            mem_req_q,   mem_req_d;
    logic            mem_we_q,    mem_we_d;
    logic [BW-1:0]   mem_be_q,    mem_be_d;
    logic [AW-1:0]   mem_addr_q,  mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]   if_rdata_q,  if_rdata_d;
    logic            if_ack_q,    if_ack_d;
    logic [DW-1:0]   dm_rdata_q,  dm_rdata_d;
    logic            dm_ack_q,    dm_ack_d;

    logic            if_forced;

    assign if_forced = bus.if_req && (wait_q == WAIT_MAX);

    // State, owner and starvation counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state, grant selection and starvation counting
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.if_req) begin
                    wait_d = '0;
                end
                if (bus.dm_req && !if_forced) begin
                    owner_d = OWN_DM;
                    state_d = ST_BUSY;
                    if (bus.if_req && (wait_q != WAIT_MAX)) begin
                        wait_d = wait_q + WCW'(1);
                    end
                end else if (bus.if_req) begin
                    owner_d = OWN_IF;
                    state_d = ST_BUSY;
                    wait_d  = '0;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // Next values of the registered memory-side and requester-side outputs
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (state_d == ST_BUSY) begin
                    mem_req_d = 1'b1;
                    if (owner_d == OWN_DM) begin
                        mem_we_d    = bus.dm_we;
                        mem_be_d    = bus.dm_be;
                        mem_addr_d  = bus.dm_addr;
                        mem_wdata_d = bus.dm_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_be_d    = '1;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (bus.mem_ready) begin
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end else if (owner_q == OWN_DM) begin
                        dm_ack_d = 1'b1;
                        // Writes leave the last read data in place
                        if (!mem_we_q) begin
                            dm_rdata_d = bus.mem_rdata;
                        end
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_rdata_q  <= '0;
            dm_ack_q    <= 1'b0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_ack_q    <= dm_ack_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_ack    = dm_ack_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-port, variable-latency unified memory between the pipeline's instruction-fetch port and its data-memory port. Sits between the IF/MEM stages and the memory model inside `top`. Each transaction is sequenced through a request/ready handshake on the memory side and returns a one-cycle ack to the owning requester. Data port has priority, with a bounded-starvation guarantee for fetch.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_WAIT`, 4, max consecutive DM grants while `if_req` pending before IF is forced

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request, held until `if_ack`
- `if_addr`  in  AW  fetch address
- `if_rdata`  out  DW  fetch data, valid while `if_ack`=1, held afterwards
- `if_ack`  out  1  one-cycle completion pulse
- `dm_req`  in  1  data request, held until `dm_ack`
- `dm_we`  in  1  1=write
- `dm_be`  in  DW/8  byte enables (writes)
- `dm_addr`  in  AW  data address
- `dm_wdata`  in  DW  write data
- `dm_rdata`  out  DW  read data, valid while `dm_ack`=1
- `dm_ack`  out  1  one-cycle completion pulse
- `mem_req`  out  1  memory request, held until `mem_ready` sampled
- `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`  out  1/DW/8/AW/DW  registered copies of the granted requester's fields
- `mem_rdata`  in  DW  memory read data, valid with `mem_ready`
- `mem_ready`  in  1  memory completion, sampled only while `mem_req`=1

## Operation
- States: IDLE, BUSY, RESP. Owner register: NONE/IF/DM.
- IDLE: if neither requests, stay. Otherwise grant DM if `dm_req`, unless `if_req` && `wait_cnt`==MAX_WAIT, which grants IF. `if_req` alone grants IF. On grant: latch the owner's fields into `mem_*`, `mem_req`<=1, go to BUSY. IF grants drive `mem_we`=0 and `mem_be`=all-ones.
- `wait_cnt`: increments on each DM grant while `if_req`=1, saturating at MAX_WAIT. Clears on an IF grant, or on any IDLE cycle with `if_req`=0.
- BUSY: on `mem_ready`=1, set `mem_req`<=0 and capture `mem_rdata` into the owner's rdata register (reads only; a DM write leaves `dm_rdata` unchanged). Pulse the owner's ack for the next cycle and go to RESP. Without `mem_ready`, hold all `mem_*` stable indefinitely (no timeout).
- RESP: ack high for exactly this cycle. All requests are ignored, so the owner's still-high req is not re-granted. Go to IDLE.
- Requester dropping req in BUSY is a protocol violation: the transaction still completes and the ack still pulses.
- `mem_ready` outside BUSY is ignored.

## Timing
- Reset (`rst`=0, async): state IDLE, owner NONE, `wait_cnt`=0. All outputs 0, including `if_rdata`/`dm_rdata`. A reset in BUSY abandons the transaction with no ack. The memory model is reset by the same `rst`.
- Zero-wait memory (`mem_ready` tied 1): req seen at edge n, `mem_req` high after n, ack high after n+1, IDLE after n+2. Occupancy is 3 cycles per transaction and a new grant is possible at edge n+3.
- Each extra wait cycle on `mem_ready` adds one cycle.
- Simultaneous `if_req`/`dm_req` in IDLE: DM wins unless the starvation limit is hit. With both held continuously, the pattern is MAX_WAIT DM grants, then 1 IF grant, repeating.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE/BUSY/RESP), owner enum (NONE/IF/DM), default widths.
- Single module, no sub-modules; the starvation counter is inline.

## Test plan
- Zero-wait IF read of 0x0000_0040, memory returns 0x2402_0005 → `mem_req` is 1 for 1 cycle, `if_ack` is 1 cycle later with `if_rdata`=0x2402_0005, next grant no earlier than cycle 3.
- DM write: addr 0x100, wdata 0xDEAD_BEEF, be 4'b0011, `mem_ready` delayed 3 cycles → `mem_*` stable for 4 cycles, then `dm_ack` 1 cycle, `dm_rdata` unchanged.
- Both requesters held high for 12 transactions, MAX_WAIT=4 → grant order DM,DM,DM,DM,IF, repeated; IF is never starved beyond 4 DM grants.
- Requester keeps req high during RESP → no duplicate grant; the next grant starts only in the following IDLE cycle.
- `rst` asserted in BUSY while `mem_ready`=0 → all outputs 0 immediately with no ack; after release, a fresh IF request completes normally.
- `mem_ready` pulsed while IDLE → no ack and no state change.
